ac_sequencer: RTL
=================

Name: ac_sequencer

Overview:
Instruction sequencer directly upstream of the accumulator (AC). Fetches 36-bit instruction words from a synchronous-read instruction memory and drives the AC's 4-bit opcode and 32-bit operand, one instruction every 3 cycles. Resolves control-flow opcodes (JMP, HALT) locally, so the AC only ever sees ADD, LOAD or NO_OP. Also keeps a program counter and a retired-instruction count for debug.

Parameters:
PC_W, 8, program counter / instruction memory address width.
START_ADDR, 0, PC value loaded on start.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin execution; honoured only in IDLE or HALTED.
stop  in  1  abort to IDLE; honoured in every state.
imem_en  out  1  instruction memory read enable.
imem_addr  out  PC_W  instruction memory read address.
imem_data  in  36  read data, valid the cycle after imem_en; [35:32] opcode, [31:0] operand.
opcode  out  4  to AC opcode input (registered).
operand  out  32  to AC operand input (registered).
pc  out  PC_W  current program counter.
busy  out  1  high in FETCH, WAIT, EXEC.
halted  out  1  high in HALTED.
retired  out  16  instructions retired since last start, saturating.

Behaviour:
- One clock (clk); reset synchronous, active-high, sampled on rising clk edge.
- Opcodes: ADD=4'h0, LOAD=4'h2, JMP=4'h8, HALT=4'hE, NO_OP=4'hF. Any other value executes as NOP.
- Reset values: state IDLE, pc=0, opcode=4'hF, operand=0, imem_en=0, imem_addr=0, busy=0, halted=0, retired=0. Reset overrides start/stop.
- IDLE: opcode=F. On start (and not stop): pc<=START_ADDR, retired<=0, go to FETCH.
- FETCH (1 cycle): imem_en=1, imem_addr=pc (combinational from state/pc). Go to WAIT.
- WAIT (1 cycle): imem_data valid. At the closing edge:
  - if op is ADD or LOAD: opcode<=op, operand<=imem_data[31:0];
  - else opcode<=F and operand holds its value.
  - Latch the instruction internally. Go to EXEC.
- EXEC (1 cycle): ADD/LOAD are presented to the AC for exactly this cycle; the AC consumes them at the closing edge. At that edge:
  - opcode<=F;
  - retired<=retired+1, saturating at 16'hFFFF;
  - JMP: pc<=operand[PC_W-1:0], go to FETCH;
  - HALT: pc holds, go to HALTED;
  - otherwise: pc<=pc+1, wrapping from 2^PC_W-1 to 0, go to FETCH.
- HALTED: opcode=F, halted=1. Start restarts exactly as from IDLE (pc<=START_ADDR, retired<=0, go to FETCH).
- stop: in any state, next state is IDLE and opcode<=F. stop has priority over start.
  - stop asserted in EXEC: the issued ADD/LOAD is still consumed by the AC at that edge and retired increments; pc does not advance.
- start while busy: ignored.
- opcode is never anything other than 0, 2 or F on the output.
- Throughput: 3 cycles per instruction; no prefetch.

Decomposition:
- Shared package ac_pkg holds opcode localparams (ADD, LOAD, JMP, HALT, NO_OP) and the state encoding (IDLE, FETCH, WAIT, EXEC, HALTED). The AC and this block both import it.
- No sub-module: FSM, PC and retire counter stay in one module. Bench uses a small behavioural ROM model (ac_imem_model) with 1-cycle read latency.

Test Plan:
- Reset mid-EXEC of a LOAD -> next cycle opcode=F, pc=0, state IDLE, retired=0, busy=0.
- ROM {0:LOAD 5, 1:ADD 3, 2:HALT}, pulse start -> opcode sequence 2 then 0, each high exactly 1 cycle, 3 cycles apart; AC out=8; halted=1; pc=2; retired=3.
- ROM {0:LOAD 1, 1:JMP 0}, run 20 cycles -> imem_addr alternates 0,1; only opcode 2 is issued; JMP never reaches the AC (opcode=F in that EXEC).
- PC_W=2, ROM all ADD 1, run 5 instructions -> pc wraps 3->0; AC out=5; retired=5.
- stop asserted during EXEC of ADD 7 with start also high -> AC adds 7, state IDLE, pc unchanged; start ignored that cycle.
- Opcode 4'h5 in ROM -> opcode output stays F, pc increments, retired increments; a start pulse while busy has no effect.

Source files
------------

// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg
// Shared definitions for the accumulator (AC) and its instruction sequencer:
// the 4-bit opcode encoding, the sequencer state encoding and a helper that
// says whether an opcode is one the AC itself executes.
// ---------------------------------------------------------------------------
package ac_pkg;

    // Opcode encoding, found in instruction word bits [35:32].
    localparam logic [3:0] ADD   = 4'h0;
    localparam logic [3:0] LOAD  = 4'h2;
    localparam logic [3:0] JMP   = 4'h8;
    localparam logic [3:0] HALT  = 4'hE;
    localparam logic [3:0] NO_OP = 4'hF;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        HALTED
    } state_e;

    // True for the opcodes forwarded to the AC; everything else is resolved
    // inside the sequencer or executed as a no-op.
    function automatic logic is_ac_op(input logic [3:0] op);
        return (op == ADD) || (op == LOAD);
    endfunction

endpackage

// File: rtl/ac_sequencer.sv
// ---------------------------------------------------------------------------
// ac_sequencer
// Fetches 36-bit instruction words from a synchronous-read instruction memory
// and presents ADD/LOAD to the accumulator for exactly one cycle, one
// instruction every three cycles (FETCH, WAIT, EXEC). JMP and HALT are
// resolved here, so the AC only ever sees ADD, LOAD or NO_OP.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      begin execution (honoured only in IDLE or HALTED)
//   stop       abort to IDLE (honoured in every state, beats start)
//   imem_en    instruction memory read enable
//   imem_addr  instruction memory read address
//   imem_data  read data, valid the cycle after imem_en; [35:32] op, [31:0] arg
//   opcode     AC opcode (registered)
//   operand    AC operand (registered)
//   pc         current program counter
//   busy       high in FETCH, WAIT, EXEC
//   halted     high in HALTED
//   retired    instructions retired since the last start, saturating
// ---------------------------------------------------------------------------
module ac_sequencer
    import ac_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [35:0]     imem_data,
    output logic [3:0]      opcode,
    output logic [31:0]     operand,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_e          state_q,   state_d;
    logic [PC_W-1:0] pc_q,      pc_d;
    logic [3:0]      opcode_q,  opcode_d;
    logic [31:0]     operand_q, operand_d;
    logic [15:0]     retired_q, retired_d;
    // Instruction latched in WAIT so EXEC can resolve control flow even though
    // the AC-facing registers are parked at NO_OP for JMP/HALT.
    logic [3:0]      ir_op_q,   ir_op_d;
    logic [PC_W-1:0] ir_tgt_q,  ir_tgt_d;

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every variable gets a hold-value default before the case so no
        // path leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        retired_d = retired_q;
        ir_op_d   = ir_op_q;
        ir_tgt_d  = ir_tgt_q;

        case (state_q)
            IDLE, HALTED: begin
                opcode_d = NO_OP;
                if (start) begin
                    state_d   = FETCH;
                    pc_d      = START_PC;
                    retired_d = '0;
                end
            end

            FETCH: state_d = WAIT;

            WAIT: begin
                ir_op_d  = imem_data[35:32];
                ir_tgt_d = imem_data[PC_W-1:0];
                if (is_ac_op(imem_data[35:32])) begin
                    opcode_d  = imem_data[35:32];
                    operand_d = imem_data[31:0];
                end else begin
                    opcode_d  = NO_OP;
                end
                state_d = EXEC;
            end

            EXEC: begin
                opcode_d  = NO_OP;
                retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
                case (ir_op_q)
                    JMP: begin
                        pc_d    = ir_tgt_q;
                        state_d = FETCH;
                    end
                    HALT: state_d = HALTED;
                    default: begin
                        pc_d    = pc_q + 1'b1;  // wraps naturally at 2^PC_W
                        state_d = FETCH;
                    end
                endcase
            end

            default: begin
                state_d  = IDLE;
                opcode_d = NO_OP;
            end
        endcase

        // stop wins over everything. An ADD/LOAD in EXEC has already been
        // presented and is consumed this edge, so it still counts as retired,
        // but the PC does not advance.
        if (stop) begin
            state_d   = IDLE;
            opcode_d  = NO_OP;
            operand_d = operand_q;
            pc_d      = pc_q;
            if (state_q != EXEC) begin
                retired_d = retired_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            opcode_q  <= NO_OP;
            operand_q <= '0;
            retired_q <= '0;
            ir_op_q   <= NO_OP;
            ir_tgt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            retired_q <= retired_d;
            ir_op_q   <= ir_op_d;
            ir_tgt_q  <= ir_tgt_d;
        end
    end

    // Memory read is issued straight from the state, no prefetch.
    assign imem_en   = (state_q == FETCH);
    assign imem_addr = imem_en ? pc_q : '0;

    assign opcode  = opcode_q;
    assign operand = operand_q;
    assign pc      = pc_q;
    assign busy    = (state_q == FETCH) || (state_q == WAIT) || (state_q == EXEC);
    assign halted  = (state_q == HALTED);
    assign retired = retired_q;

endmodule
